// File: rtl/mag_compare_pkg.sv
// Shared types, result encodings and the MSB-first priority merge for mag_compare_pipe.
package mag_compare_pkg;

  // Upper bound on the slice count the reduction function handles.
  localparam int unsigned MC_MAX_SLICES = 32;

  // One-hot compare result, MSB to LSB: {lt, gt, eq}.
  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
  } mc_result_t;

  localparam mc_result_t MC_NONE = 3'b000;
  localparam mc_result_t MC_EQ   = 3'b001;
  localparam mc_result_t MC_GT   = 3'b010;
  localparam mc_result_t MC_LT   = 3'b100;

  // The most significant unequal slice decides; unused upper slices must be padded with eq=1.
  function automatic mc_result_t mc_reduce(input logic [MC_MAX_SLICES-1:0] eq_vec,
                                           input logic [MC_MAX_SLICES-1:0] gt_vec);
    mc_result_t res;
    logic       done;
    res  = MC_EQ;
    done = 1'b0;
    for (int i = MC_MAX_SLICES - 1; i >= 0; i--) begin
      if (!done && !eq_vec[i]) begin
        res  = gt_vec[i] ? MC_GT : MC_LT;
        done = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mag_compare_slice.sv
// Combinational unsigned compare of one DIGIT-wide operand slice.
module mag_compare_slice #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             eq,
  output logic             gt
);

  // Slice flags feed the stage-1 registers of the parent.
  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/mag_compare_pipe.sv
// Two-stage streaming magnitude comparator with per-transaction signed/unsigned mode.
module mag_compare_pipe
  import mag_compare_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_eq,
  output logic             out_gt,
  output logic             out_lt
);

  localparam int unsigned NSLICE = WIDTH / DIGIT;

  // Reject geometries the slice split cannot represent.
  if ((DIGIT == 0) || (WIDTH < DIGIT) || ((WIDTH % DIGIT) != 0)) begin : g_bad_geometry
    $error("mag_compare_pipe: WIDTH must be a non-zero multiple of DIGIT");
  end
  if (NSLICE > MC_MAX_SLICES) begin : g_too_many_slices
    $error("mag_compare_pipe: WIDTH/DIGIT exceeds MC_MAX_SLICES");
  end

  logic              s1_valid;
  logic [NSLICE-1:0] s1_eq;
  logic [NSLICE-1:0] s1_gt;
  logic [NSLICE-1:0] slice_eq;
  logic [NSLICE-1:0] slice_gt;
  logic [WIDTH-1:0]  a_adj;
  logic [WIDTH-1:0]  b_adj;
  logic              s2_ready;
  logic              in_fire;
  logic              s1_fire;
  logic [MC_MAX_SLICES-1:0] eq_pad;
  logic [MC_MAX_SLICES-1:0] gt_pad;
  mc_result_t        s2_res_c;
  mc_result_t        out_res;

  // Back-pressure chain: a stage may load whenever its successor drains this cycle.
  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;
  assign in_fire  = in_valid && in_ready;
  assign s1_fire  = s1_valid && s2_ready;

  // Flipping the sign bits maps two's-complement order onto unsigned order.
  always_comb begin
    a_adj            = in_a;
    b_adj            = in_b;
    a_adj[WIDTH-1]   = in_a[WIDTH-1] ^ in_signed;
    b_adj[WIDTH-1]   = in_b[WIDTH-1] ^ in_signed;
  end

  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    mag_compare_slice #(
      .DIGIT(DIGIT)
    ) u_slice (
      .a  (a_adj[i*DIGIT +: DIGIT]),
      .b  (b_adj[i*DIGIT +: DIGIT]),
      .eq (slice_eq[i]),
      .gt (slice_gt[i])
    );
  end

  // Stage 1: capture per-slice flags; empty when drained with nothing new arriving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_eq    <= '0;
      s1_gt    <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_eq    <= slice_eq;
      s1_gt    <= slice_gt;
    end else if (s2_ready) begin
      s1_valid <= 1'b0;
    end
  end

  // Pad absent upper slices as equal so they never decide the result.
  always_comb begin
    eq_pad              = '1;
    gt_pad              = '0;
    eq_pad[NSLICE-1:0]  = s1_eq;
    gt_pad[NSLICE-1:0]  = s1_gt;
    s2_res_c            = mc_reduce(eq_pad, gt_pad);
  end

  // Stage 2: register the one-hot result; clear it once consumed with nothing behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_res   <= MC_NONE;
    end else if (s1_fire) begin
      out_valid <= 1'b1;
      out_res   <= s2_res_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_res   <= MC_NONE;
    end
  end

  assign out_eq = out_res.eq;
  assign out_gt = out_res.gt;
  assign out_lt = out_res.lt;

endmodule

// File: tb/tb_mag_compare_pipe.sv
// Directed and random checks of mag_compare_pipe against an arithmetic reference model.
module tb_mag_compare_pipe;

  localparam logic [2:0] R_EQ = 3'b001;
  localparam logic [2:0] R_GT = 3'b010;
  localparam logic [2:0] R_LT = 3'b100;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic        out_eq;
  logic        out_gt;
  logic        out_lt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_acc = 0;
  bit rnd_ready = 0;
  int cov [2][3];

  logic [2:0] exp_q [$];
  logic [2:0] got_q [$];
  int         stamp_q [$];
  bit         hold_v = 0;
  logic [2:0] hold_res = 3'b000;

  mag_compare_pipe #(.WIDTH(16), .DIGIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_eq    (out_eq),
    .out_gt    (out_gt),
    .out_lt    (out_lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer comparison in the requested mode.
  function automatic logic [2:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
    if (a == b) return R_EQ;
    if (s) return ($signed(a) > $signed(b)) ? R_GT : R_LT;
    return (a > b) ? R_GT : R_LT;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard and invariant monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [2:0] res;
    cyc++;
    if (!rst_n) begin
      hold_v = 0;
    end else begin
      res = {out_lt, out_gt, out_eq};
      if (out_valid) check("onehot", $countones(res), 1);
      else           check("idle_zero", {29'd0, res}, 0);
      if (hold_v) begin
        check("hold_valid", {31'd0, out_valid}, 1);
        check("hold_value", {29'd0, res}, {29'd0, hold_res});
      end
      if (in_valid && in_ready) begin
        logic [2:0] m;
        m = model(in_a, in_b, in_signed);
        exp_q.push_back(m);
        cov[in_signed ? 1 : 0][(m == R_EQ) ? 0 : (m == R_GT) ? 1 : 2]++;
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got %0h expected none", res);
        end else begin
          check("scoreboard", {29'd0, res}, {29'd0, exp_q.pop_front()});
        end
        got_q.push_back(res);
        stamp_q.push_back(cyc);
      end
      hold_v   = out_valid && !out_ready;
      hold_res = res;
    end
  end

  // Random back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Present one operand pair and hold it until accepted.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s);
    bit ok;
    int guard;
    guard     = 0;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_valid  = 1'b1;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      guard++;
      if (guard > 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: got no accept expected accept");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_a      = '0;
    in_b      = '0;
    in_signed = 1'b0;
    out_ready = 1'b1;

    // Reset state with in_valid asserted.
    #3;
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_outputs", {29'd0, out_lt, out_gt, out_eq}, 0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Latency: accept at edge k, valid after k+1.
    @(posedge clk); #1;
    in_a = 16'h1234; in_b = 16'h1235; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_not_yet", {31'd0, out_valid}, 0);
    @(posedge clk); #1;
    check("lat_valid", {31'd0, out_valid}, 1);
    check("lat_result", {29'd0, out_lt, out_gt, out_eq}, {29'd0, R_LT});
    drain();

    // Mode travels with operands; slice priority.
    got_q.delete();
    send(16'h8000, 16'h0001, 1'b1);
    send(16'h8000, 16'h0001, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    send(16'h1F00, 16'h10FF, 1'b0);
    send(16'h0000, 16'h000F, 1'b0);
    drain();
    check("mode_count", got_q.size(), 5);
    if (got_q.size() == 5) begin
      check("mode_signed_lt", {29'd0, got_q[0]}, {29'd0, R_LT});
      check("mode_unsigned_gt", {29'd0, got_q[1]}, {29'd0, R_GT});
      check("mode_eq", {29'd0, got_q[2]}, {29'd0, R_EQ});
      check("slice_upper_gt", {29'd0, got_q[3]}, {29'd0, R_GT});
      check("slice_low_lt", {29'd0, got_q[4]}, {29'd0, R_LT});
    end

    // Back-pressure: 5 pairs against a stalled output.
    got_q.delete();
    stamp_q.delete();
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin
        send(16'h0001, 16'h0002, 1'b0);
        send(16'h0005, 16'h0005, 1'b0);
        send(16'h0009, 16'h0003, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b1);
        send(16'h7FFF, 16'h8000, 1'b1);
      end
      begin
        int acc0;
        acc0 = n_acc;
        repeat (4) @(posedge clk);
        #2;
        check("bp_accepted", n_acc - acc0, 2);
        check("bp_in_ready", {31'd0, in_ready}, 0);
        check("bp_out_valid", {31'd0, out_valid}, 1);
        check("bp_held_first", {29'd0, out_lt, out_gt, out_eq}, {29'd0, R_LT});
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", got_q.size(), 5);
    if (got_q.size() == 5) begin
      check("bp_r0", {29'd0, got_q[0]}, {29'd0, R_LT});
      check("bp_r1", {29'd0, got_q[1]}, {29'd0, R_EQ});
      check("bp_r2", {29'd0, got_q[2]}, {29'd0, R_GT});
      check("bp_r3", {29'd0, got_q[3]}, {29'd0, R_LT});
      check("bp_r4", {29'd0, got_q[4]}, {29'd0, R_GT});
      for (int i = 1; i < 5; i++) check("bp_no_gap", stamp_q[i] - stamp_q[i-1], 1);
    end

    // Reset mid-flight discards both in-flight transactions.
    out_ready = 1'b0;
    send(16'h0100, 16'h0200, 1'b0);
    send(16'h0300, 16'h0200, 1'b0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    got_q.delete();
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 0);
    check("mid_rst_outputs", {29'd0, out_lt, out_gt, out_eq}, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_no_stale", got_q.size(), 0);
    check("post_rst_idle", {31'd0, out_valid}, 0);
    send(16'h00AA, 16'h00AA, 1'b0);
    drain();
    check("post_rst_count", got_q.size(), 1);
    if (got_q.size() == 1) check("post_rst_first", {29'd0, got_q[0]}, {29'd0, R_EQ});

    // Random operands, modes, gaps and back-pressure.
    for (int m = 0; m < 2; m++) for (int k = 0; k < 3; k++) cov[m][k] = 0;
    rnd_ready = 1;
    for (int n = 0; n < 10000; n++) begin
      logic [15:0] a;
      logic [15:0] b;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 7))
        0, 1: b = a;
        2:    b = a ^ 16'(1 << $urandom_range(0, 15));
        3:    b = {a[15:4], 4'($urandom)};
        default: ;
      endcase
      send(a, b, 1'($urandom_range(0, 1)));
    end
    rnd_ready = 0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < 3; k++)
        check($sformatf("cover_mode%0d_kind%0d", m, k), {31'd0, cov[m][k] != 0}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mag_compare_pipe.md
Name: mag_compare_pipe

Overview:
Parametrised, pipelined magnitude comparator for WIDTH-bit operands with per-transaction signed/unsigned mode and a valid/ready stream interface. The operands are split into DIGIT-bit slices. Stage 1 registers per-slice eq/gt flags. Stage 2 reduces the flags MSB-first into a registered one-hot EQ/GT/LT result. It is the streaming successor of the 4-bit combinational comparator and sits in datapaths that need back-pressure and wide operands.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of DIGIT and >= DIGIT, else elaboration error.
DIGIT, 4, slice width compared in stage 1; NSLICE = WIDTH/DIGIT.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_signed  input  1  1 = two's-complement compare, 0 = unsigned compare
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_eq  output  1  A == B
out_gt  output  1  A > B in the selected mode
out_lt  output  1  A < B in the selected mode

Behaviour:
- Reset is asynchronous and active-low: clk is the single clock; rst_n low clears state immediately, with no dependence on clk.
- Reset values: s1_valid=0, out_valid=0, out_eq=out_gt=out_lt=0, all slice flags 0.
- Transfers: input handshake when in_valid && in_ready at a rising edge; output handshake when out_valid && out_ready.
- Ready chain (combinational, no bubbles):
  - s2_ready = !out_valid || out_ready
  - in_ready = !s1_valid || s2_ready
- Signed mode: invert bit WIDTH-1 of both operands, then compare unsigned. Mode travels with its operands, so transactions may mix modes back-to-back.
- Stage 1, on input handshake:
  - For each slice i, store eq[i] = (a_i == b_i) and gt[i] = (a_i > b_i), computed on the mode-adjusted operands.
  - Set s1_valid=1.
  - If there is no input handshake but s2_ready is high, clear s1_valid.
- Stage 2, when s1_valid && s2_ready:
  - Scan slices from the MSB. The first slice with eq=0 decides: GT if its gt=1, else LT.
  - All slices equal gives EQ.
  - Register the one-hot result and set out_valid=1.
  - If out_ready is high and stage 1 is empty, clear out_valid.
- Result encoding: when out_valid=1, exactly one of {out_eq, out_gt, out_lt} is 1. When out_valid=0, all three are 0.
- Latency and throughput: 2 cycles, i.e. operands accepted at edge k give out_valid=1 after edge k+1 and are consumable at edge k+2. Throughput is 1 per cycle while out_ready=1.
- Stall (out_ready=0):
  - The output register holds its value.
  - Stage 1 holds its value once full.
  - in_ready falls after 2 un-drained transactions.
  - No result is dropped or duplicated; results emerge in order.
- Simultaneous consume and accept in the same cycle is legal at both stages (full throughput while stalled-then-released).
- Reset mid-operation: all in-flight transactions are discarded and out_valid drops asynchronously. The first post-reset result corresponds to the first post-reset input handshake.
- Inputs are don't-care while in_valid=0. Outputs hold stable while out_valid && !out_ready.
- No X on outputs when inputs are known.

Decomposition:
- Package mag_compare_pkg:
  - typedef mc_result_t as a 3-bit one-hot {lt, gt, eq}.
  - Constants MC_EQ=3'b001, MC_GT=3'b010, MC_LT=3'b100.
  - Function mc_reduce(eq_vec, gt_vec) implementing the MSB-first priority merge.
- Sub-module mag_compare_slice: combinational DIGIT-wide compare, ports a, b, eq, gt. It is instantiated NSLICE times in a generate loop.

Test Plan:
- Reset: hold rst_n=0, drive in_valid=1 -> in_ready=1, out_valid=0, outputs 0. Release, send A=0x1234, B=0x1235, unsigned, out_ready=1 -> after 2 edges out_lt=1, others 0.
- Mode: A=0x8000, B=0x0001 sent back-to-back, first signed then unsigned -> results in order LT, then GT. Then A=B=0xFFFF -> EQ.
- Slice priority: A=0x1F00, B=0x10FF -> GT; the upper slice decides despite the lower slice being LT. Also A=0x0000, B=0x000F -> LT.
- Back-pressure: stream 5 pairs with out_ready=0 for 4 cycles -> 2 accepted, then in_ready=0. Output holds the first result; after release all 5 results arrive in order with no gaps.
- Reset mid-flight: accept 2 pairs, assert rst_n=0 asynchronously between edges -> out_valid=0 immediately. After release no stale result appears.
- Random: 10k random operands/modes/out_ready with a golden-model scoreboard -> zero mismatches, one-hot always; cover EQ/GT/LT in both modes.
